// File: rtl/dffe_pkg.sv
// Shared definitions for the dffe_pipe enable-register chain: width helper,
// stall counter width and the {valid,data} stage record macro.
`ifndef DFFE_PKG_SV
`define DFFE_PKG_SV

// Packed stage record; v sits above data so {v, data} concatenations line up.
`define DFFE_STAGE_T(W) struct packed { logic v; logic [(W)-1:0] data; }

package dffe_pkg;

  localparam int STALL_CNT_W = 16;

  // Bits needed to encode values 0..n-1 (minimum 1 bit).
  function automatic int clog2(input int n);
    int r;
    int v;
    r = 0;
    v = n - 1;
    while (v > 0) begin
      r++;
      v = v >> 1;
    end
    if (r == 0) r = 1;
    return r;
  endfunction

endpackage

`endif

// File: rtl/dffe_stage.sv
// One {valid,data} pipeline register with synchronous clear, advance enable
// and a valid-kill input that clears the valid bit regardless of enable.
module dffe_stage
  import dffe_pkg::*;
#(
  parameter int               WIDTH     = 32,
  parameter logic [WIDTH-1:0] RESET_VAL = '0
) (
  input  logic           clk,
  input  logic           clr,
  input  logic           en,
  input  logic           kill,
  input  logic [WIDTH:0] d_i,
  output logic [WIDTH:0] q_o
);

  typedef `DFFE_STAGE_T(WIDTH) stage_t;

  stage_t in_s;
  stage_t stage_q;
  stage_t stage_d;

  assign in_s = d_i;

  always_comb begin
    stage_d = stage_q;
    if (en) stage_d = in_s;
    // Data still moves on a kill; only the tag is forced low.
    if (kill) stage_d.v = 1'b0;
  end

  always_ff @(posedge clk) begin
    if (clr) begin
      stage_q.v    <= 1'b0;
      stage_q.data <= RESET_VAL;
    end else begin
      stage_q <= stage_d;
    end
  end

  assign q_o = stage_q;

endmodule

// File: rtl/dffe_pipe.sv
// DEPTH-stage enable-register chain with flush and registered occupancy count.
// Optional DFFE_PIPE_STALL_CNT_EN adds a saturating stall_cnt output.
module dffe_pipe
  import dffe_pkg::*;
#(
  parameter int               WIDTH     = 32,
  parameter int               DEPTH     = 3,
  parameter logic [WIDTH-1:0] RESET_VAL = '0,
  localparam int              OCC_W     = clog2(DEPTH + 1)
) (
  input  logic             clk,
  input  logic             clr,
  input  logic             e,
  input  logic             flush,
  input  logic [WIDTH-1:0] d,
  input  logic             dv,
  output logic [WIDTH-1:0] q,
  output logic             qv,
  output logic [OCC_W-1:0] occ
`ifdef DFFE_PIPE_STALL_CNT_EN
  ,
  output logic [STALL_CNT_W-1:0] stall_cnt
`endif
);

  typedef `DFFE_STAGE_T(WIDTH) stage_t;

  // stg[0] is the input word, stg[gi+1] the output of stage gi.
  stage_t [DEPTH:0] stg;

  assign stg[0] = {dv, d};

  generate
    for (genvar gi = 0; gi < DEPTH; gi++) begin : g_stage
      dffe_stage #(
        .WIDTH    (WIDTH),
        .RESET_VAL(RESET_VAL)
      ) u_stage (
        .clk (clk),
        .clr (clr),
        .en  (e),
        .kill(flush),
        .d_i (stg[gi]),
        .q_o (stg[gi+1])
      );
    end
  endgenerate

  assign q  = stg[DEPTH].data;
  assign qv = stg[DEPTH].v;

  logic [OCC_W-1:0] occ_q;
  logic [OCC_W-1:0] occ_d;

  // Modular add/subtract is exact because the true result always fits 0..DEPTH.
  always_comb begin
    occ_d = occ_q;
    if (flush)  occ_d = '0;
    else if (e) occ_d = occ_q + OCC_W'(dv) - OCC_W'(qv);
  end

  always_ff @(posedge clk) begin
    if (clr) occ_q <= '0;
    else     occ_q <= occ_d;
  end

  assign occ = occ_q;

`ifdef DFFE_PIPE_STALL_CNT_EN
  logic [STALL_CNT_W-1:0] stall_q;
  logic [STALL_CNT_W-1:0] stall_d;

  // Counts edges where occupied stages were held back by the consumer.
  always_comb begin
    stall_d = stall_q;
    if (flush || e)
      stall_d = '0;
    else if ((occ_q != '0) && (stall_q != '1))
      stall_d = stall_q + STALL_CNT_W'(1);
  end

  always_ff @(posedge clk) begin
    if (clr) stall_q <= '0;
    else     stall_q <= stall_d;
  end

  assign stall_cnt = stall_q;
`else
  // Stall counter is not built in this configuration.
`endif

endmodule

// File: tb/tb_dffe_pipe.sv
// Randomised self-checking bench for dffe_pipe against an array-based model.
module tb_dffe_pipe;

  localparam int          WIDTH = 32;
  localparam int          DEPTH = 3;
  localparam logic [31:0] RV    = 32'hDEAD_BEEF;

  logic             clk = 1'b0;
  logic             clr = 1'b0;
  logic             e = 1'b0;
  logic             flush = 1'b0;
  logic [WIDTH-1:0] d = '0;
  logic             dv = 1'b0;
  logic [WIDTH-1:0] q;
  logic             qv;
  logic [1:0]       occ;
`ifdef DFFE_PIPE_STALL_CNT_EN
  logic [15:0]      stall_cnt;
`endif

  dffe_pipe #(
    .WIDTH    (WIDTH),
    .DEPTH    (DEPTH),
    .RESET_VAL(RV)
  ) dut (
    .clk  (clk),
    .clr  (clr),
    .e    (e),
    .flush(flush),
    .d    (d),
    .dv   (dv),
    .q    (q),
    .qv   (qv),
    .occ  (occ)
`ifdef DFFE_PIPE_STALL_CNT_EN
    ,
    .stall_cnt(stall_cnt)
`endif
  );

  always #5 clk = ~clk;

  int n_vec = 0;
  int n_err = 0;

  // Reference: plain arrays of stage contents, oldest at index DEPTH-1.
  logic [WIDTH-1:0] md [DEPTH];
  logic             mv [DEPTH];
  int               mstall = 0;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask

  function automatic int model_occ();
    int c = 0;
    for (int i = 0; i < DEPTH; i++) if (mv[i]) c++;
    return c;
  endfunction

  task automatic model_edge(input logic c, input logic en, input logic fl,
                            input logic [WIDTH-1:0] din, input logic vin);
    int occ_before;
    occ_before = model_occ();
    if (c) begin
      for (int i = 0; i < DEPTH; i++) begin
        md[i] = RV;
        mv[i] = 1'b0;
      end
      mstall = 0;
    end else begin
      if (en) begin
        for (int i = DEPTH - 1; i > 0; i--) begin
          md[i] = md[i-1];
          mv[i] = mv[i-1];
        end
        md[0] = din;
        mv[0] = vin;
      end
      if (fl) for (int i = 0; i < DEPTH; i++) mv[i] = 1'b0;
      if (fl || en)                              mstall = 0;
      else if (occ_before != 0 && mstall < 65535) mstall++;
    end
  endtask

  // Applies one edge, advances the model, and compares all outputs 1ns later.
  task automatic step(input logic c, input logic en, input logic fl,
                      input logic [WIDTH-1:0] din, input logic vin);
    clr = c; e = en; flush = fl; d = din; dv = vin;
    @(posedge clk);
    model_edge(c, en, fl, din, vin);
    #1;
    chk("q",   64'(q),   64'(md[DEPTH-1]));
    chk("qv",  64'(qv),  64'(mv[DEPTH-1]));
    chk("occ", 64'(occ), 64'(model_occ()));
`ifdef DFFE_PIPE_STALL_CNT_EN
    chk("stall_cnt", 64'(stall_cnt), 64'(mstall));
`endif
    $display("edge clr=%0b e=%0b flush=%0b d=%0h dv=%0b -> q=%0h qv=%0b occ=%0d",
             c, en, fl, din, vin, q, qv, occ);
  endtask

  initial begin
    #2;
    // Reset
    step(1, 0, 0, 32'h0, 0);
    chk("rst_q",   64'(q),   64'hDEAD_BEEF);
    chk("rst_qv",  64'(qv),  64'd0);
    chk("rst_occ", 64'(occ), 64'd0);

    // Stream 1..4
    for (int i = 1; i <= 4; i++) begin
      step(0, 1, 0, WIDTH'(i), 1);
      chk("stream_occ", 64'(occ), (i < 3) ? 64'(i) : 64'd3);
      if (i >= 3) chk("stream_q", 64'(q), 64'(i - 2));
    end

    // Fill then stall
    step(0, 1, 0, 32'hA, 1);
    step(0, 1, 0, 32'hB, 1);
    step(0, 1, 0, 32'hC, 1);
    for (int i = 0; i < 5; i++) step(0, 0, 0, 32'hF, 1);
    chk("stall_q",   64'(q),   64'hA);
    chk("stall_occ", 64'(occ), 64'd3);
`ifdef DFFE_PIPE_STALL_CNT_EN
    chk("stall_cnt5", 64'(stall_cnt), 64'd5);
`endif
    step(0, 1, 0, 32'hF, 1);
    chk("resume_q", 64'(q), 64'hB);

    // Flush with advance, then bubbles stay invalid
    step(0, 1, 1, 32'h55, 1);
    chk("flush_qv",  64'(qv),  64'd0);
    chk("flush_occ", 64'(occ), 64'd0);
    for (int i = 0; i < 3; i++) begin
      step(0, 1, 0, 32'h0, 0);
      chk("post_flush_qv", 64'(qv), 64'd0);
    end

    // Bubbles 1,0,1 with 7,8,9
    step(0, 1, 0, 32'h7, 1);
    step(0, 1, 0, 32'h8, 0);
    step(0, 1, 0, 32'h9, 1);
    chk("bub_q0", 64'(q), 64'h7); chk("bub_v0", 64'(qv), 64'd1);
    step(0, 1, 0, 32'h0, 0);
    chk("bub_q1", 64'(q), 64'h8); chk("bub_v1", 64'(qv), 64'd0);
    step(0, 1, 0, 32'h0, 0);
    chk("bub_q2", 64'(q), 64'h9); chk("bub_v2", 64'(qv), 64'd1);

    // Priority: clr beats flush and e
    step(0, 1, 0, 32'h1, 1);
    step(0, 1, 0, 32'h2, 1);
    step(1, 1, 1, 32'h5, 1);
    chk("prio_q",   64'(q),   64'hDEAD_BEEF);
    chk("prio_qv",  64'(qv),  64'd0);
    chk("prio_occ", 64'(occ), 64'd0);

    // Randomised traffic
    for (int i = 0; i < 400; i++) begin
      step(($urandom_range(0, 49) == 0),
           ($urandom_range(0, 9) < 7),
           ($urandom_range(0, 11) == 0),
           WIDTH'($urandom),
           1'($urandom_range(0, 1)));
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
